dmem_controller: RTL
====================

# dmem_controller

Parametrised, handshaked successor to the core's byte-addressable data memory. Accepts one load/store request at a time from the MEM stage over a valid/ready interface. Storage is four byte-lane banks with synchronous read and write, and each access returns a one-cycle response pulse. Adds range checking, mode checking and misaligned-access handling, with a two-cycle split path for misaligned accesses.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words; power of two, ≥ 2; capacity is DEPTH_WORDS*4 bytes.
- AW, $clog2(DEPTH_WORDS), word-index width (derived; not overridden).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; a request is accepted on the edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_mode  in  3  DM_* access mode (funct3 encoding).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse; there is no backpressure on responses.
- rsp_rdata  out  32  load result, sign- or zero-extended per mode; 0 for stores and errors.
- rsp_err  out  1  access fault; qualified by rsp_valid.

## Operation
- Modes:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other mode, including store modes 100/101, is an error.
- Access size is 1, 2 or 4 bytes. Byte offset is o = addr[1:0]. Word index is w = addr[AW+1:2].
- Error checks, evaluated at acceptance:
  - Invalid mode.
  - addr + size − 1 ≥ DEPTH_WORDS*4. Address arithmetic is unsigned, 33 bits; there is no wrap-around.
  - Misaligned access when SPLIT is not compiled in.
- An errored request writes nothing. It still produces exactly one response with rsp_err = 1 and rsp_rdata = 0.
- Aligned or non-crossing accesses (o + size ≤ 4) use a single word access.
- Stores drive per-lane byte enables. Data is shifted left by 8*o; no read-modify-write is needed.
- Loads read the whole word, shift right by 8*o, then extend per mode.
- Little-endian throughout: the byte at addr lands in rdata[7:0].
- FSM states: IDLE, RESP, SPLIT_HI.
  - IDLE: req_ready = 1. On accept of a non-crossing or errored request → RESP. On accept of a crossing request (SPLIT only) → SPLIT_HI.
  - SPLIT_HI: req_ready = 0. Accesses word w+1 for the upper lanes, then → RESP.
  - RESP: rsp_valid = 1, req_ready = 0, then → IDLE.
- One request per response; there is no pipelining of back-to-back requests.

## Timing
- Reset values: state IDLE, req_ready 0 while rst is high, rsp_valid 0, rsp_rdata 0, rsp_err 0. Memory contents are not reset.
- Non-crossing access: accepted at edge T, response valid in cycle T+1. Store data is visible to a load accepted at T+2, the next possible accept.
- Crossing access: low part at edge T, high part at edge T+1, response valid in cycle T+2.
- Issue rate: one request per 2 cycles, or 3 cycles when split.
- Reset during SPLIT_HI or RESP: the FSM returns to IDLE and no response is issued. A low-part store already committed at T remains in memory.
- req_* inputs are sampled only at acceptance and are don't-care afterwards.

## Configuration
- DMEM_MISALIGN_SPLIT_EN
  - Defined: an access crossing a word boundary (e.g. LW at o = 1, LH at o = 3) is performed as two word accesses via SPLIT_HI. Partial load data is held in a 24-bit holding register.
  - Undefined: a crossing access is a fault (rsp_err = 1, no write, latency 1). SPLIT_HI and the holding register are not built.
  - Non-crossing misaligned accesses (e.g. LH at o = 1) are legal in both builds.

## Structure
- Shared package (defines.vh): DM_LB/LH/LW/LBU/LHU/SB/SH/SW mode codes, FSM state encodings, and the DMEM_MISALIGN_SPLIT_EN switch.
- Sub-module dmem_bank: DEPTH_WORDS x 8 byte lane with synchronous write-enable and synchronous read. It is instantiated four times, one per lane, each with its own word index so a split access can address w and w+1 lanes independently.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_rdata 0xDEADBEEF, rsp_err 0. Each response arrives 1 cycle after its accept.
- After the above: LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x11 → 0xFFFFADBE; LHU @0x10 → 0x0000BEEF.
- SW 0x11223344 @0x3FE (DEPTH_WORDS = 256) → rsp_err 1; a following LW @0x3FC shows the word unchanged. LW with mode 011 → rsp_err 1, rsp_rdata 0.
- SPLIT build: SW 0xA1B2C3D4 @0x21, then LW @0x21 → 0xA1B2C3D4 with response 2 cycles after accept; LW @0x20 → byte 0xD4 in [15:8], byte 0xB2 at 0x23 and 0xA1 at 0x24. Non-SPLIT build: same SW → rsp_err 1, no write.
- Assert rst during SPLIT_HI of SW @0x21 → no rsp_valid; req_ready is 0 while rst is high and 1 on the first cycle after rst deasserts. Bytes 0x21–0x23 are updated; byte 0x24 is unchanged.
- req_valid held high with back-to-back requests → req_ready is never high while rsp_valid is high, and rsp_valid pulses exactly once per accept.

Source files
------------

// File: rtl/dmem_controller_pkg.sv
// Shared mode codes, FSM states and helpers for dmem_controller.
// Build switch: DMEM_MISALIGN_SPLIT_EN enables two-cycle word-crossing accesses.
package dmem_controller_pkg;

  localparam logic [2:0] DM_LB  = 3'b000;
  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_LW  = 3'b010;
  localparam logic [2:0] DM_LBU = 3'b100;
  localparam logic [2:0] DM_LHU = 3'b101;
  localparam logic [2:0] DM_SB  = 3'b000;
  localparam logic [2:0] DM_SH  = 3'b001;
  localparam logic [2:0] DM_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESP,
    ST_SPLIT_HI
  } state_e;

  function automatic logic [2:0] access_size(input logic [2:0] mode);
    case (mode[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic mode_valid(input logic we, input logic [2:0] mode);
    if (we) return mode inside {DM_SB, DM_SH, DM_SW};
    return mode inside {DM_LB, DM_LH, DM_LW, DM_LBU, DM_LHU};
  endfunction

endpackage

// File: rtl/dmem_controller_bank.sv
// One byte lane of data memory: synchronous write and registered read (old data on collision).
module dmem_bank #(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH_WORDS];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem[idx_i] <= wdata_i;
      rdata_q <= mem[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_controller.sv
// Handshaked byte-addressable data memory with range/mode checks and misaligned handling.
// Build switch: DMEM_MISALIGN_SPLIT_EN (word-crossing accesses split over two cycles, else fault).
module dmem_controller
  import dmem_controller_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [1:0]  off_q;
  logic [2:0]  mode_q;
  logic        we_q, err_q;

  logic          accept, err_now, crossing, range_bad;
  logic [1:0]    off;
  logic [AW-1:0] widx;
  logic [2:0]    size;
  logic [32:0]   last_byte;
  logic [3:0]    be_base, lo_be;
  logic [31:0]   lo_data;

  logic          lane_en;
  logic [3:0]    lane_we;
  logic [7:0]    lane_wd  [4];
  logic [AW-1:0] lane_idx [4];
  logic [7:0]    lane_rd  [4];
  logic [31:0]   rd_word, lo_word, ld_shifted, ld_ext;

  assign off       = req_addr[1:0];
  assign widx      = req_addr[AW+1:2];
  assign size      = access_size(req_mode);
  assign last_byte = {1'b0, req_addr} + {30'b0, size} - 33'd1;
  assign range_bad = last_byte >= (33'(DEPTH_WORDS) << 2);
  assign crossing  = ({1'b0, off} + size) > 3'd4;
  assign be_base   = (size == 3'd1) ? 4'b0001 : (size == 3'd2) ? 4'b0011 : 4'b1111;
  assign lo_be     = be_base << off;
  assign lo_data   = req_wdata << {off, 3'b000};

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [AW-1:0] w_q;
  logic          split_q;
  logic [2:0]    hi_be_q, hi_be, n_hi;
  logic [23:0]   hold_q, hi_data;

  assign err_now = !mode_valid(req_we, req_mode) || range_bad;
  assign hi_data = 24'(req_wdata >> (6'd32 - {1'b0, off, 3'b000}));

  always_comb begin
    n_hi = {1'b0, off} + size - 3'd4;
    for (int unsigned l = 0; l < 3; l++) hi_be[l] = 3'(l) < n_hi;
  end

  // hold_q carries upper store bytes into SPLIT_HI, or the low word's upper bytes for loads
  always_ff @(posedge clk) begin
    if (accept) begin
      split_q <= crossing && !err_now;
      w_q     <= widx;
      hi_be_q <= hi_be;
      hold_q  <= hi_data;
    end else if (state_q == ST_SPLIT_HI && !we_q) begin
      hold_q  <= rd_word[31:8];
    end
  end
`else
  assign err_now = !mode_valid(req_we, req_mode) || range_bad || crossing;
`endif

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    lane_en = accept;
    lane_we = (accept && req_we && !err_now) ? lo_be : '0;
    for (int unsigned l = 0; l < 4; l++) begin
      lane_wd[l]  = lo_data[8*l +: 8];
      lane_idx[l] = widx;
    end
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (state_q == ST_SPLIT_HI) begin
      lane_en    = !rst;
      lane_we    = (we_q && !rst) ? {1'b0, hi_be_q} : '0;
      lane_wd[0] = hold_q[7:0];
      lane_wd[1] = hold_q[15:8];
      lane_wd[2] = hold_q[23:16];
      lane_wd[3] = 8'h00;
      for (int unsigned l = 0; l < 4; l++) lane_idx[l] = w_q + AW'(1);
    end
`endif
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
      .clk_i   (clk),
      .en_i    (lane_en),
      .we_i    (lane_we[g]),
      .idx_i   (lane_idx[g]),
      .wdata_i (lane_wd[g]),
      .rdata_o (lane_rd[g])
    );
  end

  assign rd_word = {lane_rd[3], lane_rd[2], lane_rd[1], lane_rd[0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RESP;
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (accept && crossing && !err_now) state_d = ST_SPLIT_HI;
`endif
      end
      ST_SPLIT_HI: state_d = ST_RESP;
      ST_RESP:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      off_q  <= off;
      mode_q <= req_mode;
      we_q   <= req_we;
      err_q  <= err_now;
    end
  end

  // Split loads present {word w+1, word w} so one shifter serves both paths
  always_comb begin
    lo_word = rd_word;
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (split_q) lo_word = {hold_q, 8'h00};
`endif
    ld_shifted = 32'({rd_word, lo_word} >> {off_q, 3'b000});
    case (mode_q)
      DM_LB:   ld_ext = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      DM_LH:   ld_ext = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      DM_LBU:  ld_ext = {24'b0, ld_shifted[7:0]};
      DM_LHU:  ld_ext = {16'b0, ld_shifted[15:0]};
      default: ld_ext = ld_shifted;
    endcase
  end

  assign rsp_valid = (state_q == ST_RESP) && !rst;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? ld_ext : '0;

endmodule
